rx: RTL and testbench
=====================

# rx

UART receive path with an 8-entry byte buffer, the receive-side counterpart of the board's UART transmit path. It oversamples the incoming serial line (8N1, LSB first) with a per-bit clock counter, recovers bytes at mid-bit, and pushes them into a first-word-fall-through FIFO. Downstream logic drains the FIFO with a valid/ready handshake. Framing errors and overruns are reported as single-cycle pulses.

## Interface
- `TIMER_BITS`, 32: width of the baud timer.
- `CLOCKS_PER_BAUD`, 868: clk cycles per bit; must be ≥ 4.
- `FIFO_AW`, 3: FIFO address width; depth = 2^FIFO_AW.

- `clk`  in  1  single clock; all logic rising-edge.
- `i_reset_n`  in  1  asynchronous, active-low reset.
- `uart_txd_in`  in  1  asynchronous serial line; idles high.
- `i_ready`  in  1  consumer accepts the head byte this cycle.
- `o_valid`  out  1  FIFO non-empty; `o_data` is valid.
- `o_data`  out  8  FIFO head byte.
- `o_count`  out  FIFO_AW+1  current FIFO occupancy.
- `o_frame_err`  out  1  one-cycle pulse: stop bit sampled low.
- `o_overrun`  out  1  one-cycle pulse: good byte dropped because the FIFO was full.

## Operation
- **Synchronizer:** `uart_txd_in` passes through a 2-flop synchronizer that resets to 1. Only the synchronized value (`rxs`) is used.
- **States:**
  - ARM: wait for `rxs`=1, then go to IDLE. This is the reset state. It prevents a false start when the line is low at reset release.
  - IDLE: on `rxs`=0, load timer = CLOCKS_PER_BAUD/2 − 1 (integer divide) and go to START.
  - START: when timer reaches 0, sample. If `rxs`=1 (glitch), go to IDLE. Otherwise load timer = CLOCKS_PER_BAUD − 1, clear the bit index, and go to DATA.
  - DATA: on each timer expiry, shift `rxs` into bit[index] (LSB first) and reload the timer. After bit 7, go to STOP.
  - STOP: on timer expiry, sample.
    - `rxs`=1: push the byte if the FIFO is not full, otherwise pulse `o_overrun`. Go to IDLE.
    - `rxs`=0: pulse `o_frame_err`, discard the byte, go to ARM (waits for the line to return high; covers a break).
- **FIFO:** circular buffer with read and write pointers of FIFO_AW+1 bits; the MSB distinguishes full from empty.
  - Pop occurs when `o_valid && i_ready`.
  - `i_ready` while empty is ignored.
  - Push and pop in the same cycle: both happen, count is unchanged. This holds even when full, because the pop frees the slot the push uses.
- **Timer:** decrements by 1 per cycle in START/DATA/STOP. An expiry compare is only at 0; no wrap occurs.

## Timing
- **Reference point:** let cycle 0 be the first cycle `rxs`=0 in IDLE. `rxs` lags the pin by 2 cycles.
- **Sample points:**
  - Start bit: cycle CLOCKS_PER_BAUD/2.
  - Data bit k (k = 0..7): cycle CLOCKS_PER_BAUD/2 + (k+1)·CLOCKS_PER_BAUD.
  - Stop bit: cycle CLOCKS_PER_BAUD/2 + 9·CLOCKS_PER_BAUD.
- **Stop-sample cycle:**
  - Push is registered on this cycle.
  - `o_valid`/`o_data` update on the next cycle.
  - `o_frame_err`/`o_overrun` are high for exactly the cycle after this one.
- **Next frame:** IDLE is re-entered the cycle after the stop sample, so a new start edge can be accepted 1 cycle after the stop sample.
- **Pop latency:** a pop updates `o_data`/`o_valid`/`o_count` on the next edge (FWFT).
- **Reset values** (asynchronous, any cycle including mid-frame):
  - `o_valid`=0, `o_data`=0, `o_count`=0, `o_frame_err`=0, `o_overrun`=0.
  - State = ARM; FIFO emptied.
  - A partial frame in progress is discarded.

## Test plan
- **Single byte:** CLOCKS_PER_BAUD=16, drive 0x55 8N1 → `o_valid` rises 1 cycle after the stop sample with `o_data`=0x55, `o_count`=1. `i_ready`=1 → `o_valid`=0, `o_count`=0 the next cycle.
- **Back-to-back:** 0xA3, 0x0F, 0xFF with no idle gap between frames, `i_ready`=0 → `o_count`=3. Pops return 0xA3, 0x0F, 0xFF in order; no error pulses.
- **Glitch and frame error:**
  - Glitch: low pulse of 5 cycles (< 8) on the idle line → no push, state returns to IDLE.
  - Frame error: frame 0x3C with stop bit driven low → one `o_frame_err` pulse, no push. No new frame is accepted until the line has gone high.
- **Overrun:** 9 frames with `i_ready`=0 and depth 8 → `o_count`=8, one `o_overrun` pulse on the 9th frame, and the FIFO contents are the first 8 bytes.
- **Full plus simultaneous pop:** with the FIFO full, assert `i_ready` on the cycle the 9th push occurs → no overrun, `o_count` stays 8, and the new byte ends up at the tail.
- **Reset mid-frame:** assert `i_reset_n`=0 during data bit 4 with the line low at release → outputs 0 and FIFO empty. Idle-high line plus frame 0x81 → exactly one byte, 0x81, received.

Source files
------------

// File: rtl/rx.sv
// UART receive path (8N1, LSB first) with a first-word-fall-through byte FIFO.
//
// Ports:
//   clk          - single clock, rising edge
//   i_reset_n    - asynchronous active-low reset
//   uart_txd_in  - asynchronous serial line, idles high
//   i_ready      - consumer accepts the head byte this cycle
//   o_valid      - FIFO non-empty, o_data holds the head byte
//   o_data       - FIFO head byte
//   o_count      - FIFO occupancy
//   o_frame_err  - one-cycle pulse: stop bit sampled low
//   o_overrun    - one-cycle pulse: good byte dropped, FIFO full
module rx #(
  parameter int unsigned TIMER_BITS      = 32,
  parameter int unsigned CLOCKS_PER_BAUD = 868,
  parameter int unsigned FIFO_AW         = 3
) (
  input  logic               clk,
  input  logic               i_reset_n,
  input  logic               uart_txd_in,
  input  logic               i_ready,
  output logic               o_valid,
  output logic [7:0]         o_data,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_frame_err,
  output logic               o_overrun
);

  localparam int unsigned DEPTH     = 1 << FIFO_AW;
  localparam int unsigned PTR_W     = FIFO_AW + 1;
  localparam int unsigned HALF_LOAD = CLOCKS_PER_BAUD / 2 - 1;
  localparam int unsigned FULL_LOAD = CLOCKS_PER_BAUD - 1;

  typedef enum logic [2:0] {
    S_ARM,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // Two-flop synchronizer; resets high so the line looks idle
  logic [1:0] r_sync;
  logic       w_rxs;

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) r_sync <= 2'b11;
    else            r_sync <= {r_sync[0], uart_txd_in};
  end

  assign w_rxs = r_sync[1];

  // Receiver state and datapath registers
  state_t                  r_state, w_state_next;
  logic [TIMER_BITS-1:0]   r_timer, w_timer_next;
  logic [2:0]              r_bit_idx, w_bit_idx_next;
  logic [7:0]              r_shift, w_shift_next;
  logic                    w_push_req;
  logic                    w_frame_err;
  logic                    w_timer_zero;

  assign w_timer_zero = (r_timer == '0);

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state   <= S_ARM;
      r_timer   <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
    end else begin
      r_state   <= w_state_next;
      r_timer   <= w_timer_next;
      r_bit_idx <= w_bit_idx_next;
      r_shift   <= w_shift_next;
    end
  end

  // Next-state: bit timing and byte assembly
  always_comb begin
    w_state_next   = r_state;
    w_timer_next   = r_timer;
    w_bit_idx_next = r_bit_idx;
    w_shift_next   = r_shift;
    w_push_req     = 1'b0;
    w_frame_err    = 1'b0;
    case (r_state)
      S_ARM: begin
        if (w_rxs) w_state_next = S_IDLE;
      end
      S_IDLE: begin
        if (!w_rxs) begin
          w_timer_next = TIMER_BITS'(HALF_LOAD);
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (w_timer_zero) begin
          if (w_rxs) begin
            w_state_next = S_IDLE;
          end else begin
            w_timer_next   = TIMER_BITS'(FULL_LOAD);
            w_bit_idx_next = '0;
            w_state_next   = S_DATA;
          end
        end else begin
          w_timer_next = r_timer - TIMER_BITS'(1);
        end
      end
      S_DATA: begin
        if (w_timer_zero) begin
          w_shift_next[r_bit_idx] = w_rxs;
          w_timer_next            = TIMER_BITS'(FULL_LOAD);
          w_bit_idx_next          = r_bit_idx + 3'd1;
          if (r_bit_idx == 3'd7) w_state_next = S_STOP;
        end else begin
          w_timer_next = r_timer - TIMER_BITS'(1);
        end
      end
      S_STOP: begin
        if (w_timer_zero) begin
          if (w_rxs) begin
            w_push_req   = 1'b1;
            w_state_next = S_IDLE;
          end else begin
            // Low stop bit: wait in ARM until the line recovers (covers a break)
            w_frame_err  = 1'b1;
            w_state_next = S_ARM;
          end
        end else begin
          w_timer_next = r_timer - TIMER_BITS'(1);
        end
      end
      default: w_state_next = S_ARM;
    endcase
  end

  // FIFO: extra pointer MSB separates full from empty
  logic [7:0]        r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wptr, r_rptr;
  logic [PTR_W-1:0]  w_wptr_next, w_rptr_next;
  logic [PTR_W-1:0]  r_count, w_count_next;
  logic              r_valid;
  logic [7:0]        r_data, w_head_next;
  logic              r_frame_err, r_overrun;
  logic              w_full, w_pop, w_push, w_overrun;

  assign w_full    = (r_count == PTR_W'(DEPTH));
  assign w_pop     = r_valid && i_ready;
  // A pop in the same cycle frees the slot a push into a full FIFO needs
  assign w_push    = w_push_req && (!w_full || w_pop);
  assign w_overrun = w_push_req && w_full && !w_pop;

  always_comb begin
    w_wptr_next  = w_push ? r_wptr + PTR_W'(1) : r_wptr;
    w_rptr_next  = w_pop  ? r_rptr + PTR_W'(1) : r_rptr;
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + PTR_W'(1);
      2'b01:   w_count_next = r_count - PTR_W'(1);
      default: w_count_next = r_count;
    endcase
    // Head bypass when the byte being pushed becomes the new head
    if (w_push && (w_rptr_next == r_wptr)) w_head_next = r_shift;
    else                                   w_head_next = r_mem[w_rptr_next[FIFO_AW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[FIFO_AW-1:0]] <= r_shift;
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_wptr      <= w_wptr_next;
      r_rptr      <= w_rptr_next;
      r_count     <= w_count_next;
      r_valid     <= (w_count_next != '0);
      r_data      <= w_head_next;
      r_frame_err <= w_frame_err;
      r_overrun   <= w_overrun;
    end
  end

  assign o_valid     = r_valid;
  assign o_data      = r_data;
  assign o_count     = r_count;
  assign o_frame_err = r_frame_err;
  assign o_overrun   = r_overrun;

endmodule

// File: tb/tb_rx.sv
// Directed self-checking bench for rx with CLOCKS_PER_BAUD = 16, FIFO depth 8.
module tb_rx;

  localparam int unsigned C = 16;

  logic       clk;
  logic       i_reset_n;
  logic       uart_txd_in;
  logic       i_ready;
  logic       o_valid;
  logic [7:0] o_data;
  logic [3:0] o_count;
  logic       o_frame_err;
  logic       o_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int fe_cnt   = 0;
  int ov_cnt   = 0;

  rx #(
    .TIMER_BITS     (32),
    .CLOCKS_PER_BAUD(C),
    .FIFO_AW        (3)
  ) dut (
    .clk        (clk),
    .i_reset_n  (i_reset_n),
    .uart_txd_in(uart_txd_in),
    .i_ready    (i_ready),
    .o_valid    (o_valid),
    .o_data     (o_data),
    .o_count    (o_count),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles each error pulse is high, sampled away from the active edge
  always @(negedge clk) begin
    if (o_frame_err) fe_cnt++;
    if (o_overrun)   ov_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_frame(input logic [7:0] b, input logic stop_bit);
    uart_txd_in = 1'b0;
    cyc(C);
    for (int i = 0; i < 8; i++) begin
      uart_txd_in = b[i];
      cyc(C);
    end
    uart_txd_in = stop_bit;
    cyc(C);
  endtask

  task automatic pop_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, 32'(o_valid), 32'd1);
    check({tag, "_data"}, 32'(o_data), 32'(exp));
    i_ready = 1'b1;
    cyc(1);
    i_ready = 1'b0;
  endtask

  initial begin
    i_reset_n   = 1'b0;
    uart_txd_in = 1'b1;
    i_ready     = 1'b0;
    cyc(3);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_data", 32'(o_data), 32'd0);
    check("rst_count", 32'(o_count), 32'd0);
    check("rst_ferr", 32'(o_frame_err), 32'd0);
    check("rst_ovr", 32'(o_overrun), 32'd0);
    i_reset_n = 1'b1;
    cyc(5);

    // Single byte with exact latency: stop sample ends on the 155th edge after the pin drop
    fork
      drive_frame(8'h55, 1'b1);
      begin
        cyc(154);
        check("t1_valid_before", 32'(o_valid), 32'd0);
        cyc(1);
        check("t1_valid", 32'(o_valid), 32'd1);
        check("t1_data", 32'(o_data), 32'h55);
        check("t1_count", 32'(o_count), 32'd1);
        i_ready = 1'b1;
        cyc(1);
        i_ready = 1'b0;
        check("t1_valid_pop", 32'(o_valid), 32'd0);
        check("t1_count_pop", 32'(o_count), 32'd0);
      end
    join
    cyc(5);

    // Back-to-back frames, no idle gap
    drive_frame(8'hA3, 1'b1);
    drive_frame(8'h0F, 1'b1);
    drive_frame(8'hFF, 1'b1);
    cyc(20);
    check("t2_count", 32'(o_count), 32'd3);
    pop_check("t2_a3", 8'hA3);
    pop_check("t2_0f", 8'h0F);
    pop_check("t2_ff", 8'hFF);
    check("t2_count_end", 32'(o_count), 32'd0);
    check("t2_ferr", 32'(fe_cnt), 32'd0);
    check("t2_ovr", 32'(ov_cnt), 32'd0);

    // Short low glitch is rejected
    uart_txd_in = 1'b0;
    cyc(5);
    uart_txd_in = 1'b1;
    cyc(30);
    check("t3_glitch_count", 32'(o_count), 32'd0);
    check("t3_glitch_ferr", 32'(fe_cnt), 32'd0);

    // Frame error, then line held low: no further frames accepted
    drive_frame(8'h3C, 1'b0);
    cyc(200);
    check("t3_ferr", 32'(fe_cnt), 32'd1);
    check("t3_ferr_count", 32'(o_count), 32'd0);
    uart_txd_in = 1'b1;
    cyc(20);
    check("t3_ferr_hold", 32'(fe_cnt), 32'd1);
    drive_frame(8'h5A, 1'b1);
    cyc(5);
    check("t3_after_count", 32'(o_count), 32'd1);
    pop_check("t3_after", 8'h5A);

    // Overrun: nine frames into depth 8
    for (int k = 1; k <= 9; k++) drive_frame(8'(k), 1'b1);
    cyc(10);
    check("t4_count", 32'(o_count), 32'd8);
    check("t4_ovr", 32'(ov_cnt), 32'd1);
    check("t4_ferr", 32'(fe_cnt), 32'd1);
    for (int k = 1; k <= 8; k++) pop_check("t4_pop", 8'(k));
    check("t4_count_end", 32'(o_count), 32'd0);

    // Full FIFO with a pop on the same cycle as the ninth push
    for (int k = 1; k <= 8; k++) drive_frame(8'(8'h10 + k), 1'b1);
    cyc(5);
    check("t5_full", 32'(o_count), 32'd8);
    fork
      drive_frame(8'h19, 1'b1);
      begin
        cyc(154);
        i_ready = 1'b1;
        cyc(1);
        i_ready = 1'b0;
        check("t5_count", 32'(o_count), 32'd8);
        check("t5_head", 32'(o_data), 32'h12);
      end
    join
    cyc(5);
    check("t5_ovr", 32'(ov_cnt), 32'd1);
    for (int k = 2; k <= 9; k++) pop_check("t5_pop", 8'(8'h10 + k));
    check("t5_count_end", 32'(o_count), 32'd0);

    // Reset during data bit 4 with the line low at release
    drive_frame(8'h77, 1'b1);
    cyc(5);
    check("t6_pre_count", 32'(o_count), 32'd1);
    uart_txd_in = 1'b0;
    cyc(5 * C + 5);
    i_reset_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(o_valid), 32'd0);
    check("t6_rst_data", 32'(o_data), 32'd0);
    check("t6_rst_count", 32'(o_count), 32'd0);
    cyc(3);
    i_reset_n = 1'b1;
    cyc(3);
    uart_txd_in = 1'b1;
    cyc(40);
    check("t6_idle_count", 32'(o_count), 32'd0);
    check("t6_idle_ferr", 32'(fe_cnt), 32'd1);
    drive_frame(8'h81, 1'b1);
    cyc(20);
    check("t6_count", 32'(o_count), 32'd1);
    pop_check("t6_81", 8'h81);
    check("t6_count_end", 32'(o_count), 32'd0);
    check("t6_ovr", 32'(ov_cnt), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
